// File: rtl/cmsdk_mcu_ahb_arb2.sv
// cmsdk_mcu_ahb_arb2
//   Two-master AHB-Lite arbiter. M0 (CPU) and M1 (DMA/test) share one AHB-Lite
//   path into the slave decode. A master that loses arbitration has its address
//   phase captured in a one-entry buffer. It is then held off with hready=0
//   until the buffered transfer completes on the shared bus.
//
// Parameters
//   AW        address width
//   RR_MODE   0: fixed priority M0 > M1, 1: alternate on contention
//   MAX_HOLD  consecutive transfers an owner may issue before yielding to a
//             waiting master (1..255)
//
// Ports
//   HCLK, HRESETn                  clock, synchronous active-low reset
//   m0_*/m1_* haddr..hwdata  in    per-master address/control/write data
//   m0_*/m1_* hready/hrdata/hresp  per-master response
//   HADDR/HTRANS/HSIZE/HWRITE/HWDATA  out  shared address phase and write data
//   HREADY/HRDATA/HRESP        in  shared slave response
//   hmaster                   out  address-phase owner (0=M0, 1=M1)
//   dp_master                 out  data-phase owner (00 none, 01 M0, 10 M1)

module cmsdk_mcu_ahb_arb2 #(
  parameter int AW       = 32,
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 8
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] m0_haddr,
  input  logic [1:0]    m0_htrans,
  input  logic [2:0]    m0_hsize,
  input  logic          m0_hwrite,
  input  logic [31:0]   m0_hwdata,
  output logic          m0_hready,
  output logic [31:0]   m0_hrdata,
  output logic          m0_hresp,
  input  logic [AW-1:0] m1_haddr,
  input  logic [1:0]    m1_htrans,
  input  logic [2:0]    m1_hsize,
  input  logic          m1_hwrite,
  input  logic [31:0]   m1_hwdata,
  output logic          m1_hready,
  output logic [31:0]   m1_hrdata,
  output logic          m1_hresp,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic [31:0]   HRDATA,
  input  logic          HRESP,
  output logic          hmaster,
  output logic [1:0]    dp_master
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] DP_NONE   = 2'b00;
  localparam logic [1:0] DP_M0     = 2'b01;
  localparam logic [1:0] DP_M1     = 2'b10;
  localparam logic [7:0] HOLD_LIM  = 8'(MAX_HOLD);

  logic          owner_q;
  logic [1:0]    dp_q;
  logic [7:0]    hold_cnt;

  // Buffered transfers are always replayed as NONSEQ, so no HTRANS is stored.
  logic          pend0_q, pend1_q;
  logic [AW-1:0] pend0_addr, pend1_addr;
  logic [2:0]    pend0_size, pend1_size;
  logic          pend0_write, pend1_write;

  logic          req0, req1, grant, gnt_req, issue, issue0, issue1;
  logic          load0, load1, drop0, drop1;

  // Per-master responses. A master that is not the data-phase owner only
  // stalls while it has a buffered transfer outstanding.
  always_comb begin
    m0_hready = 1'b1;
    m0_hresp  = 1'b0;
    m0_hrdata = '0;
    m1_hready = 1'b1;
    m1_hresp  = 1'b0;
    m1_hrdata = '0;
    if (HRESETn) begin
      if (dp_q == DP_M0) begin
        m0_hready = HREADY;
        m0_hresp  = HRESP;
        m0_hrdata = HRDATA;
      end else begin
        m0_hready = !pend0_q;
      end
      if (dp_q == DP_M1) begin
        m1_hready = HREADY;
        m1_hresp  = HRESP;
        m1_hrdata = HRDATA;
      end else begin
        m1_hready = !pend1_q;
      end
    end
  end

  assign req0 = HRESETn & ((m0_htrans[1] & m0_hready) | pend0_q);
  assign req1 = HRESETn & ((m1_htrans[1] & m1_hready) | pend1_q);

  // Ownership only moves on HREADY=1 so a stalled address phase stays put.
  always_comb begin
    grant = owner_q;
    if (HREADY) begin
      if (req0 && !req1) begin
        grant = 1'b0;
      end else if (req1 && !req0) begin
        grant = 1'b1;
      end else if (req0 && req1) begin
        if (hold_cnt >= HOLD_LIM) begin
          grant = !owner_q;
        end else if (RR_MODE != 0) begin
          grant = !owner_q;
        end else begin
          grant = 1'b0;
        end
      end
    end
  end

  assign gnt_req = grant ? req1 : req0;
  assign issue   = HREADY & gnt_req;
  assign issue0  = issue & !grant;
  assign issue1  = issue & grant;

  always_comb begin
    HADDR  = '0;
    HTRANS = TR_IDLE;
    HSIZE  = '0;
    HWRITE = 1'b0;
    if (gnt_req) begin
      if (!grant) begin
        if (pend0_q) begin
          HADDR  = pend0_addr;
          HTRANS = TR_NONSEQ;
          HSIZE  = pend0_size;
          HWRITE = pend0_write;
        end else begin
          HADDR  = m0_haddr;
          HTRANS = m0_htrans;
          HSIZE  = m0_hsize;
          HWRITE = m0_hwrite;
        end
      end else begin
        if (pend1_q) begin
          HADDR  = pend1_addr;
          HTRANS = TR_NONSEQ;
          HSIZE  = pend1_size;
          HWRITE = pend1_write;
        end else begin
          HADDR  = m1_haddr;
          HTRANS = m1_htrans;
          HSIZE  = m1_hsize;
          HWRITE = m1_hwrite;
        end
      end
    end
  end

  always_comb begin
    HWDATA = '0;
    if (dp_q == DP_M0) begin
      HWDATA = m0_hwdata;
    end else if (dp_q == DP_M1) begin
      HWDATA = m1_hwdata;
    end
  end

  assign hmaster   = HRESETn & grant;
  assign dp_master = dp_q;

  assign load0 = m0_htrans[1] & m0_hready & !pend0_q & !issue0;
  assign load1 = m1_htrans[1] & m1_hready & !pend1_q & !issue1;
  // First ERROR cycle cancels any transfer the erroring master has queued.
  assign drop0 = HRESP & !HREADY & (dp_q == DP_M0);
  assign drop1 = HRESP & !HREADY & (dp_q == DP_M1);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      owner_q     <= 1'b0;
      dp_q        <= DP_NONE;
      hold_cnt    <= '0;
      pend0_q     <= 1'b0;
      pend1_q     <= 1'b0;
      pend0_addr  <= '0;
      pend1_addr  <= '0;
      pend0_size  <= '0;
      pend1_size  <= '0;
      pend0_write <= 1'b0;
      pend1_write <= 1'b0;
    end else begin
      if (HREADY) begin
        owner_q <= grant;
        dp_q    <= issue ? (grant ? DP_M1 : DP_M0) : DP_NONE;
        if (issue) begin
          if (grant != owner_q) begin
            hold_cnt <= 8'd1;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
      end
      if (load0) begin
        pend0_q     <= 1'b1;
        pend0_addr  <= m0_haddr;
        pend0_size  <= m0_hsize;
        pend0_write <= m0_hwrite;
      end else if (issue0 || drop0) begin
        pend0_q <= 1'b0;
      end
      if (load1) begin
        pend1_q     <= 1'b1;
        pend1_addr  <= m1_haddr;
        pend1_size  <= m1_hsize;
        pend1_write <= m1_hwrite;
      end else if (issue1 || drop1) begin
        pend1_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmsdk_mcu_ahb_arb2.sv
// Directed bench for the two-master arbiter (fixed priority, MAX_HOLD=4).
module tb_cmsdk_mcu_ahb_arb2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [2:0]  m0_hsize, m1_hsize;
  logic        m0_hwrite, m1_hwrite;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, dp_master;
  logic [2:0]  hsize;
  logic        hwrite, hready, hresp, hmaster;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmsdk_mcu_ahb_arb2 #(.AW(32), .RR_MODE(0), .MAX_HOLD(4)) dut (
    .HCLK(clk), .HRESETn(rst_n),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hsize(m0_hsize),
    .m0_hwrite(m0_hwrite), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready),
    .m0_hrdata(m0_hrdata), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hsize(m1_hsize),
    .m1_hwrite(m1_hwrite), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready),
    .m1_hrdata(m1_hrdata), .m1_hresp(m1_hresp),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite),
    .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrdata), .HRESP(hresp),
    .hmaster(hmaster), .dp_master(dp_master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; new inputs are applied here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic m0_drive(input logic [1:0] tr, input logic [31:0] a, input logic w);
    m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hsize = 3'd2;
  endtask

  task automatic m1_drive(input logic [1:0] tr, input logic [31:0] a, input logic w);
    m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hsize = 3'd2;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_drive(2'b00, 32'h0, 1'b0); m0_hwdata = '0;
    m1_drive(2'b00, 32'h0, 1'b0); m1_hwdata = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'hDEAD_BEEF;

    // Reset state
    tick(); settle();
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hmaster", {31'd0, hmaster}, 32'd0);
    chk("rst_dp", {30'd0, dp_master}, 32'd0);
    chk("rst_m0_hready", {31'd0, m0_hready}, 32'd1);
    chk("rst_m1_hready", {31'd0, m1_hready}, 32'd1);
    chk("rst_m0_hrdata", m0_hrdata, 32'd0);
    chk("rst_m1_hresp", {31'd0, m1_hresp}, 32'd0);
    rst_n = 1'b1;

    // 1: M0-only read, zero-wait slave
    tick(); m0_drive(2'b10, 32'h0000_0004, 1'b0); settle();
    chk("t1_htrans", {30'd0, htrans}, 32'd2);
    chk("t1_haddr", haddr, 32'h0000_0004);
    chk("t1_hmaster", {31'd0, hmaster}, 32'd0);
    chk("t1_m1_hready_a", {31'd0, m1_hready}, 32'd1);
    tick(); m0_drive(2'b00, 32'h0, 1'b0); hrdata = 32'h1234_5678; settle();
    chk("t1_m0_hrdata", m0_hrdata, 32'h1234_5678);
    chk("t1_m0_hready", {31'd0, m0_hready}, 32'd1);
    chk("t1_dp", {30'd0, dp_master}, 32'd1);
    chk("t1_m1_hready_d", {31'd0, m1_hready}, 32'd1);
    chk("t1_m1_hrdata", m1_hrdata, 32'd0);
    tick(); settle();
    chk("t1_dp_idle", {30'd0, dp_master}, 32'd0);

    // 2: contention, M0 issued, M1 buffered and replayed next cycle
    m0_drive(2'b10, 32'h2000_0000, 1'b0);
    m1_drive(2'b10, 32'h2000_0010, 1'b1); settle();
    chk("t2_haddr_m0", haddr, 32'h2000_0000);
    chk("t2_hmaster_m0", {31'd0, hmaster}, 32'd0);
    chk("t2_m1_accept", {31'd0, m1_hready}, 32'd1);
    tick();
    m0_drive(2'b00, 32'h0, 1'b0); m1_drive(2'b00, 32'h0, 1'b0);
    m1_hwdata = 32'hA5A5_A5A5; hrdata = 32'h1111_2222; settle();
    chk("t2_m1_stall", {31'd0, m1_hready}, 32'd0);
    chk("t2_hmaster_m1", {31'd0, hmaster}, 32'd1);
    chk("t2_htrans_m1", {30'd0, htrans}, 32'd2);
    chk("t2_haddr_m1", haddr, 32'h2000_0010);
    chk("t2_hwrite_m1", {31'd0, hwrite}, 32'd1);
    chk("t2_m0_hrdata", m0_hrdata, 32'h1111_2222);
    tick(); settle();
    chk("t2_dp_m1", {30'd0, dp_master}, 32'd2);
    chk("t2_hwdata", hwdata, 32'hA5A5_A5A5);
    chk("t2_m1_done", {31'd0, m1_hready}, 32'd1);
    tick(); m1_hwdata = '0;

    // 4: M1 transfer with 3 slave wait states; M0 request arrives meanwhile
    m1_drive(2'b10, 32'h4000_0000, 1'b0); settle();
    chk("t4_hmaster", {31'd0, hmaster}, 32'd1);
    chk("t4_htrans", {30'd0, htrans}, 32'd2);
    tick(); m1_drive(2'b00, 32'h0, 1'b0); hready = 1'b0;
    m0_drive(2'b10, 32'h0000_0100, 1'b0); settle();
    chk("t4_w1_m1_hready", {31'd0, m1_hready}, 32'd0);
    chk("t4_w1_hmaster", {31'd0, hmaster}, 32'd1);
    chk("t4_w1_htrans", {30'd0, htrans}, 32'd0);
    chk("t4_w1_m0_accept", {31'd0, m0_hready}, 32'd1);
    for (int i = 2; i <= 3; i++) begin
      tick(); m0_drive(2'b00, 32'h0, 1'b0); settle();
      chk("t4_wn_m1_hready", {31'd0, m1_hready}, 32'd0);
      chk("t4_wn_m0_hready", {31'd0, m0_hready}, 32'd0);
      chk("t4_wn_hmaster", {31'd0, hmaster}, 32'd1);
      chk("t4_wn_htrans", {30'd0, htrans}, 32'd0);
    end
    tick(); hready = 1'b1; hrdata = 32'h4444_0000; settle();
    chk("t4_m1_done", {31'd0, m1_hready}, 32'd1);
    chk("t4_m1_hrdata", m1_hrdata, 32'h4444_0000);
    chk("t4_switch_m0", {31'd0, hmaster}, 32'd0);
    chk("t4_m0_replay", {30'd0, htrans}, 32'd2);
    chk("t4_m0_haddr", haddr, 32'h0000_0100);
    tick(); settle();
    chk("t4_m0_done", {31'd0, m0_hready}, 32'd1);
    chk("t4_dp_m0", {30'd0, dp_master}, 32'd1);
    tick();

    // 5: ERROR on M0 read while M1 is buffered
    m0_drive(2'b10, 32'h0000_0500, 1'b0);
    m1_drive(2'b10, 32'h0000_0600, 1'b1); settle();
    chk("t5_hmaster", {31'd0, hmaster}, 32'd0);
    tick(); m0_drive(2'b00, 32'h0, 1'b0); m1_drive(2'b00, 32'h0, 1'b0);
    m1_hwdata = 32'h5A5A_5A5A; hready = 1'b0; hresp = 1'b1; settle();
    chk("t5_e1_m0_hresp", {31'd0, m0_hresp}, 32'd1);
    chk("t5_e1_m0_hready", {31'd0, m0_hready}, 32'd0);
    chk("t5_e1_m1_hresp", {31'd0, m1_hresp}, 32'd0);
    chk("t5_e1_m1_hready", {31'd0, m1_hready}, 32'd0);
    chk("t5_e1_htrans", {30'd0, htrans}, 32'd0);
    tick(); hready = 1'b1; settle();
    chk("t5_e2_m0_hresp", {31'd0, m0_hresp}, 32'd1);
    chk("t5_e2_m0_hready", {31'd0, m0_hready}, 32'd1);
    chk("t5_e2_hmaster", {31'd0, hmaster}, 32'd1);
    chk("t5_e2_haddr", haddr, 32'h0000_0600);
    tick(); hresp = 1'b0; settle();
    chk("t5_m1_hready", {31'd0, m1_hready}, 32'd1);
    chk("t5_m1_hresp", {31'd0, m1_hresp}, 32'd0);
    chk("t5_hwdata", hwdata, 32'h5A5A_5A5A);
    tick(); m1_hwdata = '0;

    // 6: reset pulse while M1 is buffered
    m0_drive(2'b10, 32'h0000_0700, 1'b0);
    m1_drive(2'b10, 32'h0000_0800, 1'b1); settle();
    chk("t6_m1_accept", {31'd0, m1_hready}, 32'd1);
    tick(); m0_drive(2'b00, 32'h0, 1'b0); m1_drive(2'b00, 32'h0, 1'b0);
    rst_n = 1'b0; settle();
    chk("t6_rst_htrans", {30'd0, htrans}, 32'd0);
    chk("t6_rst_haddr", haddr, 32'd0);
    chk("t6_rst_m1_hready", {31'd0, m1_hready}, 32'd1);
    tick(); rst_n = 1'b1; settle();
    chk("t6_pend_m1", {31'd0, dut.pend1_q}, 32'd0);
    chk("t6_dp", {30'd0, dp_master}, 32'd0);
    chk("t6_hmaster", {31'd0, hmaster}, 32'd0);
    chk("t6_htrans", {30'd0, htrans}, 32'd0);
    chk("t6_m1_hready", {31'd0, m1_hready}, 32'd1);
    chk("t6_m0_hready", {31'd0, m0_hready}, 32'd1);
    tick(); settle();
    chk("t6_no_replay", {30'd0, htrans}, 32'd0);

    // 3: MAX_HOLD=4 burst from M0 with M1 waiting (hold count fresh from reset)
    m0_drive(2'b10, 32'h0000_1000, 1'b0);
    m1_drive(2'b10, 32'h0000_9000, 1'b1); settle();
    chk("t3_c0_hmaster", {31'd0, hmaster}, 32'd0);
    chk("t3_c0_htrans", {30'd0, htrans}, 32'd2);
    for (int i = 1; i <= 3; i++) begin
      tick(); m0_drive(2'b11, 32'h0000_1000 + 32'(4 * i), 1'b0);
      m1_drive(2'b00, 32'h0, 1'b0); m1_hwdata = 32'hC3C3_C3C3; settle();
      chk("t3_seq_hmaster", {31'd0, hmaster}, 32'd0);
      chk("t3_seq_haddr", haddr, 32'h0000_1000 + 32'(4 * i));
      chk("t3_seq_htrans", {30'd0, htrans}, 32'd3);
      chk("t3_seq_m1_stall", {31'd0, m1_hready}, 32'd0);
    end
    tick(); m0_drive(2'b11, 32'h0000_1010, 1'b0); settle();
    chk("t3_yield_hmaster", {31'd0, hmaster}, 32'd1);
    chk("t3_yield_haddr", haddr, 32'h0000_9000);
    chk("t3_yield_htrans", {30'd0, htrans}, 32'd2);
    chk("t3_yield_m0_hready", {31'd0, m0_hready}, 32'd1);
    tick(); m0_drive(2'b00, 32'h0, 1'b0); settle();
    chk("t3_m0_back", {31'd0, hmaster}, 32'd0);
    chk("t3_m0_nonseq", {30'd0, htrans}, 32'd2);
    chk("t3_m0_haddr", haddr, 32'h0000_1010);
    chk("t3_m0_stall", {31'd0, m0_hready}, 32'd0);
    chk("t3_m1_done", {31'd0, m1_hready}, 32'd1);
    chk("t3_hwdata", hwdata, 32'hC3C3_C3C3);
    tick(); settle();
    chk("t3_m0_done", {31'd0, m0_hready}, 32'd1);
    chk("t3_dp_m0", {30'd0, dp_master}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
